// File: rtl/baud_pkg.sv
// Shared constants and the reset-default divisor calculation for the baud tick generator.
package baud_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int PHASE_W_DEF    = $clog2(OVERSAMPLE_DEF);

    // Fixed-point divisor with frac_bits fractional bits, truncated toward zero.
    function automatic longint unsigned default_div(
        input longint unsigned clock_hz,
        input longint unsigned baud,
        input longint unsigned oversample,
        input int              frac_bits
    );
        return (clock_hz << frac_bits) / (baud * oversample);
    endfunction

endpackage

// File: rtl/baud_frac_accum.sv
// Fractional accumulator producing the next oversample period P = div + carry.
// With BAUD_GEN_FRAC_EN undefined there is no accumulator and P = div.
module baud_frac_accum #(
    parameter int DIV_BITS  = 16,
    parameter int FRAC_BITS = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_clear,
    input  logic                 i_advance,
    input  logic [DIV_BITS-1:0]  i_div,
    input  logic [FRAC_BITS-1:0] i_frac,
    output logic [DIV_BITS:0]    o_period
);

`ifdef BAUD_GEN_FRAC_EN
    logic [FRAC_BITS-1:0] acc_reg;
    logic [FRAC_BITS-1:0] acc_next;
    logic                 carry;

    assign {carry, acc_next} = {1'b0, acc_reg} + {1'b0, i_frac};
    assign o_period          = {1'b0, i_div} + {{DIV_BITS{1'b0}}, carry};

    always_ff @(posedge i_clock) begin
        if (i_reset || i_clear) begin
            acc_reg <= '0;
        end else if (i_advance) begin
            acc_reg <= acc_next;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = ^{i_clock, i_reset, i_clear, i_advance, i_frac};
    assign o_period      = {1'b0, i_div};
`endif

endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-divisor baud tick generator: oversample, mid-bit and bit ticks with
// glitch-free divisor reload and phase restart. Fractional part enabled by BAUD_GEN_FRAC_EN.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int CLOCK      = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DIV_BITS   = 16,
    parameter int FRAC_BITS  = 4
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_sync,
    input  logic                          i_load,
    input  logic [DIV_BITS-1:0]           i_div_int,
    input  logic [FRAC_BITS-1:0]          i_div_frac,
    output logic                          o_tick_os,
    output logic                          o_tick_mid,
    output logic                          o_tick_bit,
    output logic [$clog2(OVERSAMPLE)-1:0] o_phase,
    output logic                          o_load_pending
);

    localparam int PHASE_W = $clog2(OVERSAMPLE);

`ifdef BAUD_GEN_FRAC_EN
    localparam longint unsigned DEF_FIX =
        default_div(64'(CLOCK), 64'(BAUD_RATE), 64'(OVERSAMPLE), FRAC_BITS);
    localparam logic [DIV_BITS-1:0]  DEF_INT  = DIV_BITS'(DEF_FIX >> FRAC_BITS);
    localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(DEF_FIX);
`else
    localparam longint unsigned DEF_FIX =
        default_div(64'(CLOCK), 64'(BAUD_RATE), 64'(OVERSAMPLE), 0);
    localparam logic [DIV_BITS-1:0]  DEF_INT  = DIV_BITS'(DEF_FIX);
    localparam logic [FRAC_BITS-1:0] DEF_FRAC = '0;
`endif

    localparam logic [PHASE_W-1:0] PH_LAST    = PHASE_W'(OVERSAMPLE - 1);
    localparam logic [PHASE_W-1:0] PH_PRE_MID = PHASE_W'(OVERSAMPLE / 2 - 1);

    logic [DIV_BITS-1:0]  cnt_reg, cnt_next;
    logic [DIV_BITS-1:0]  act_int_reg, act_int_next, shd_int_reg, shd_int_next;
    logic [FRAC_BITS-1:0] act_frac_reg, act_frac_next, shd_frac_reg, shd_frac_next;
    logic [PHASE_W-1:0]   phase_reg, phase_next;
    logic                 pending_reg, pending_next;
    logic                 tick_os_reg, tick_os_next;
    logic                 tick_mid_reg, tick_mid_next;
    logic                 tick_bit_reg, tick_bit_next;

    logic                 reload, bit_edge, apply;
    logic [DIV_BITS-1:0]  sel_int, div_eff;
    logic [FRAC_BITS-1:0] sel_frac;
    logic [DIV_BITS:0]    period;

    assign reload   = i_enable && !i_sync && (cnt_reg == '0);
    assign bit_edge = reload && (phase_reg == PH_LAST);
    assign apply    = pending_reg && (i_sync || !i_enable || bit_edge);

    // On an apply edge the reload already uses the new divisor, so the
    // period that starts at the bit boundary is the first new one.
    assign sel_int  = apply ? shd_int_reg : act_int_reg;
    assign sel_frac = apply ? shd_frac_reg : act_frac_reg;
    assign div_eff  = (sel_int == '0) ? DIV_BITS'(1) : sel_int;

    baud_frac_accum #(
        .DIV_BITS  (DIV_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_accum (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_clear   (i_sync),
        .i_advance (reload),
        .i_div     (div_eff),
        .i_frac    (sel_frac),
        .o_period  (period)
    );

    always_comb begin
        cnt_next      = cnt_reg;
        phase_next    = phase_reg;
        act_int_next  = act_int_reg;
        act_frac_next = act_frac_reg;
        shd_int_next  = shd_int_reg;
        shd_frac_next = shd_frac_reg;
        pending_next  = pending_reg;
        tick_os_next  = 1'b0;
        tick_mid_next = 1'b0;
        tick_bit_next = 1'b0;

        if (apply) begin
            act_int_next  = shd_int_reg;
            act_frac_next = shd_frac_reg;
            pending_next  = 1'b0;
        end
        // A load on an apply edge lands in the shadow and waits for the next one.
        if (i_load) begin
            shd_int_next  = i_div_int;
            shd_frac_next = i_div_frac;
            pending_next  = 1'b1;
        end

        if (i_sync) begin
            cnt_next   = div_eff - DIV_BITS'(1);
            phase_next = '0;
        end else if (reload) begin
            cnt_next      = DIV_BITS'(period - (DIV_BITS + 1)'(1));
            phase_next    = phase_reg + PHASE_W'(1);
            tick_os_next  = 1'b1;
            tick_mid_next = (phase_reg == PH_PRE_MID);
            tick_bit_next = bit_edge;
        end else if (i_enable) begin
            cnt_next = cnt_reg - DIV_BITS'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            cnt_reg      <= DEF_INT - DIV_BITS'(1);
            phase_reg    <= '0;
            act_int_reg  <= DEF_INT;
            act_frac_reg <= DEF_FRAC;
            shd_int_reg  <= DEF_INT;
            shd_frac_reg <= DEF_FRAC;
            pending_reg  <= 1'b0;
            tick_os_reg  <= 1'b0;
            tick_mid_reg <= 1'b0;
            tick_bit_reg <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            phase_reg    <= phase_next;
            act_int_reg  <= act_int_next;
            act_frac_reg <= act_frac_next;
            shd_int_reg  <= shd_int_next;
            shd_frac_reg <= shd_frac_next;
            pending_reg  <= pending_next;
            tick_os_reg  <= tick_os_next;
            tick_mid_reg <= tick_mid_next;
            tick_bit_reg <= tick_bit_next;
        end
    end

    assign o_tick_os      = tick_os_reg;
    assign o_tick_mid     = tick_mid_reg;
    assign o_tick_bit     = tick_bit_reg;
    assign o_phase        = phase_reg;
    assign o_load_pending = pending_reg;

endmodule

// File: doc/baud_gen_frac.md
# baud_gen_frac

Parametrised fractional-divisor baud tick generator for the UART. It produces an oversample tick, a mid-bit tick and a bit tick from one system clock. The divisor is runtime-reloadable, and reloads are applied glitch-free on bit boundaries. A phase-restart input lets the RX path align to a start-bit edge.

## Interface
- CLOCK, 100000000, system clock frequency in Hz
- BAUD_RATE, 9600, reset-default baud rate
- OVERSAMPLE, 16, oversample ticks per bit; power of two, ≥4
- DIV_BITS, 16, width of integer divisor part
- FRAC_BITS, 4, width of fractional divisor part (1/2^FRAC_BITS cycle resolution)
- i_clock  in  1  system clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  count enable; low freezes counter, phase and accumulator
- i_sync  in  1  restart phase: counter, phase and accumulator restart this edge
- i_load  in  1  one-cycle strobe capturing i_div_int/i_div_frac into shadow register
- i_div_int  in  DIV_BITS  integer cycles per oversample tick; 0 treated as 1
- i_div_frac  in  FRAC_BITS  fractional cycles per oversample tick
- o_tick_os  out  1  one-cycle oversample tick
- o_tick_mid  out  1  one-cycle tick when phase becomes OVERSAMPLE/2 (RX sample point)
- o_tick_bit  out  1  one-cycle tick when phase wraps OVERSAMPLE-1→0
- o_phase  out  $clog2(OVERSAMPLE)  current oversample phase
- o_load_pending  out  1  shadow divisor captured but not yet active

## Operation
- Active divisor: D = div_int + div_frac/2^FRAC_BITS clock cycles per oversample tick.
- Reset defaults: DEF = floor(CLOCK·2^FRAC_BITS/(BAUD_RATE·OVERSAMPLE)); int = DEF>>FRAC_BITS, frac = low FRAC_BITS bits. For the defaults: int = 651, frac = 0.
- Period generation: a down-counter reloads with P-1 each time it reaches 0. P = div_int + carry, where {carry, acc} = acc + div_frac is computed at each reload. The reset and sync loads use P = div_int, with acc = 0.
- The os tick is asserted on the edge where the counter is 0 and i_enable = 1. Phase increments mod OVERSAMPLE on each os tick. o_tick_mid and o_tick_bit coincide with the corresponding o_tick_os.
- Reload: i_load copies the inputs into the shadow register and sets o_load_pending.
  - The shadow becomes active on the next edge that asserts o_tick_bit, on an i_sync edge, or on any edge with i_enable = 0. o_load_pending clears on that same edge.
  - If i_load coincides with a bit-boundary edge, the new value waits for the following boundary.
  - A second i_load before the apply overwrites the shadow.
- Priority per edge: i_reset > i_sync > i_load apply > counting.
- Registered outputs at reset: o_tick_os = o_tick_mid = o_tick_bit = 0, o_phase = 0, o_load_pending = 0. Counter = default int - 1, acc = 0.

## Timing
- All outputs are registered. A tick is high for exactly one cycle.
- The first o_tick_os is high in the cycle after the P-th enabled edge following reset or sync. Subsequent ticks are spaced by the period sequence.
- i_enable low: ticks are forced 0 and all state is held. Counting resumes exactly where it stopped.
- i_sync edge: ticks are 0 that cycle. The next o_tick_os comes P cycles later with phase = 1. The next o_tick_bit comes after OVERSAMPLE os ticks.
- Reset mid-bit: outputs return to reset values on the next edge, and any pending load is discarded.

## Configuration
- BAUD_GEN_FRAC_EN defined: fractional accumulator present; behaviour as above.
- BAUD_GEN_FRAC_EN undefined: i_div_frac is ignored, there is no accumulator, P = div_int always, and the reset default is int = floor(CLOCK/(BAUD_RATE·OVERSAMPLE)). Port list is unchanged.

## Structure
- Shared package baud_pkg:
  - default-divisor computation function
  - OVERSAMPLE default constant
  - phase-width constant
- Sub-module baud_frac_accum holds the accumulator and outputs the next period P. Reset and sync clear it; it advances on each reload.
- The top level holds the counter, phase counter, shadow register and reload control.

## Test plan
- Defaults, enable held high: o_tick_os every 651 cycles; o_tick_bit every 10416 cycles; o_tick_mid at phase 8.
- i_load int = 3, frac = 8, FRAC_BITS = 4, then i_sync: os intervals 3,3,4,3,4,… (7 cycles per 2 ticks steady state).
- int = 3, frac = 0, i_load mid-bit: o_load_pending = 1 until the next o_tick_bit edge; the old period holds until then and the new period starts after it.
- i_div_int = 0: o_tick_os is high every cycle; o_tick_bit fires every 16 cycles.
- Drop i_enable for 20 cycles mid-period: no ticks, o_phase frozen, and the next tick is delayed by exactly 20 cycles.
- i_sync with int = 10 at phase 11: o_phase = 0, and the next os tick arrives 10 cycles later with phase = 1.
